// File: rtl/demux_sched_pkg.sv
// Shared types for the demux select scheduler: FSM states, channel index and
// the queued request format.
package demux_sched_pkg;

  localparam int CHANNELS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRIVE,
    GUARD
  } sched_state_t;

  typedef logic [$clog2(CHANNELS)-1:0] chan_idx_t;

  typedef struct packed {
    chan_idx_t dest;
    logic      data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/sched_fifo.sv
// Small synchronous FIFO with full/empty flags; pop_data always shows the head
// entry so the consumer can load it on the same edge that pops it.
module sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is still legal when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_sel_scheduler.sv
// Sequencer for the 1-to-8 demux: queues routing requests and replays each as
// SETUP / DRIVE / GUARD so the select lines only move while a is low.
module demux_sel_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int HOLD_W       = 4,
  parameter int GUARD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_dest,
  input  logic              in_data,
  output logic              a,
  output logic              s0,
  output logic              s1,
  output logic              s2,
  output logic              busy,
  output logic              done
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  sched_state_t      state, state_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [GW-1:0]     guard_cnt, guard_n;
  chan_idx_t         sel, sel_n;
  logic              data_q, data_n;
  logic              pop;
  logic              can_pop;
  logic              full;
  logic              empty;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  assign push_entry = '{dest: in_dest, data: in_data};
  assign in_ready   = !full;
  assign can_pop    = en && !empty;

  sched_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid && in_ready),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty)
  );

  // Popping loads the new select at the same edge, so the select can only move
  // on the edge leaving IDLE or the last GUARD cycle, both with a already low.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    guard_n = guard_cnt;
    sel_n   = sel;
    data_n  = data_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          sel_n   = head.dest;
          data_n  = head.data;
          hold_n  = (hold_len == '0) ? HOLD_W'(1) : hold_len;
          state_n = SETUP;
        end
      end
      SETUP: begin
        state_n = DRIVE;
      end
      DRIVE: begin
        if (hold_cnt <= HOLD_W'(1)) begin
          state_n = GUARD;
          guard_n = GUARD_LOAD;
        end else begin
          hold_n = hold_cnt - HOLD_W'(1);
        end
      end
      GUARD: begin
        if (guard_cnt == '0) begin
          if (can_pop) begin
            pop     = 1'b1;
            sel_n   = head.dest;
            data_n  = head.data;
            hold_n  = (hold_len == '0) ? HOLD_W'(1) : hold_len;
            state_n = SETUP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          guard_n = guard_cnt - GW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      guard_cnt <= '0;
      sel       <= '0;
      data_q    <= 1'b0;
      a         <= 1'b0;
      s0        <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      guard_cnt <= guard_n;
      sel       <= sel_n;
      data_q    <= data_n;
      a         <= (state_n == DRIVE) && data_n;
      s0        <= sel_n[2];
      s1        <= sel_n[1];
      s2        <= sel_n[0];
      busy      <= (state_n != IDLE);
      done      <= (state_n == GUARD) && (guard_n == '0);
    end
  end

endmodule

// File: tb/tb_demux_sel_scheduler.sv
// Self-checking bench for demux_sel_scheduler: directed vector table, hand-built
// corner sequences and random traffic against a slot-timing reference model.
module tb_demux_sel_scheduler;

  localparam int DEPTH        = 4;
  localparam int HOLD_W       = 4;
  localparam int GUARD_CYCLES = 1;
  localparam int NVEC         = 17;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [HOLD_W-1:0] hold_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_dest = '0;
  logic              in_data = 1'b0;
  logic              a, s0, s1, s2, busy, done;

  always #5 clk = ~clk;

  demux_sel_scheduler #(
    .DEPTH(DEPTH),
    .HOLD_W(HOLD_W),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold_len(hold_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .a(a), .s0(s0), .s1(s1), .s2(s2), .busy(busy), .done(done)
  );

  typedef struct {
    logic [2:0] dest;
    logic       data;
  } req_t;

  typedef struct {
    logic              en;
    logic              valid;
    logic [2:0]        dest;
    logic              data;
    logic [HOLD_W-1:0] hold;
    logic [6:0]        exp;
  } vec_t;

  // Model: each popped request owns a slot of 1 + N + GUARD_CYCLES cycles from its pop edge.
  req_t       q[$];
  int         edge_k;
  int         slot_p;
  int         slot_n;
  logic       cur_valid;
  logic [2:0] m_sel;
  logic       m_data;

  int n_tests = 0;
  int n_fails = 0;

  vec_t       vecs[NVEC];
  logic [2:0] done_order[$];

  function automatic vec_t mk(logic e, logic v, logic [2:0] d, logic dat,
                              logic [HOLD_W-1:0] h, logic [6:0] x);
    vec_t r;
    r.en = e; r.valid = v; r.dest = d; r.data = dat; r.hold = h; r.exp = x;
    return r;
  endfunction

  function automatic logic [6:0] dut_out();
    return {in_ready, a, s0, s1, s2, busy, done};
  endfunction

  function automatic logic [6:0] model_out();
    int   rel;
    logic er, ea, eb, ed;
    rel = edge_k - slot_p;
    er  = (q.size() < DEPTH);
    eb  = cur_valid && (rel <= slot_n + GUARD_CYCLES);
    ea  = cur_valid && m_data && (rel >= 1) && (rel <= slot_n);
    ed  = cur_valid && (rel == slot_n + GUARD_CYCLES);
    return {er, ea, m_sel, eb, ed};
  endfunction

  task automatic model_reset();
    q.delete();
    edge_k    = 0;
    slot_p    = 0;
    slot_n    = 0;
    cur_valid = 1'b0;
    m_sel     = '0;
    m_data    = 1'b0;
  endtask

  task automatic model_edge();
    int   pre_size;
    req_t r;
    edge_k++;
    pre_size = q.size();
    if (en && pre_size > 0 && (!cur_valid || edge_k >= slot_p + slot_n + GUARD_CYCLES + 1)) begin
      r         = q.pop_front();
      slot_p    = edge_k;
      slot_n    = (hold_len == 0) ? 1 : int'(hold_len);
      m_sel     = r.dest;
      m_data    = r.data;
      cur_valid = 1'b1;
    end
    if (in_valid && pre_size < DEPTH) begin
      r.dest = in_dest;
      r.data = in_data;
      q.push_back(r);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name);
    check(name, 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic [2:0] d,
                               input logic dat, input logic [HOLD_W-1:0] h);
    en       = e;
    in_valid = v;
    in_dest  = d;
    in_data  = dat;
    hold_len = h;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic runEntry(input string name, input logic [2:0] d, input logic dat,
                          input logic [HOLD_W-1:0] h, input int exp_a, input int exp_busy);
    int a_cnt, d_cnt, b_cnt;
    a_cnt = 0; d_cnt = 0; b_cnt = 0;
    applyStimulus(1'b1, 1'b1, d, dat, h);
    checkOutput({name, "_push"});
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, d, dat, h);
      checkOutput(name);
      if (a === 1'b1) a_cnt++;
      if (done === 1'b1) d_cnt++;
      if (busy === 1'b1) b_cnt++;
    end
    check({name, "_a_cycles"}, 32'(a_cnt), 32'(exp_a));
    check({name, "_done_pulses"}, 32'(d_cnt), 32'd1);
    check({name, "_busy_cycles"}, 32'(b_cnt), 32'(exp_busy));
  endtask

  initial begin
    int   d_cnt;
    logic rdy;

    // Single entry dest=5 data=1 hold=3, then back-to-back dest=0 / dest=7 with hold=2.
    vecs[0]  = mk(1, 1, 3'd5, 1, 4'd3, 7'b1000000);
    vecs[1]  = mk(1, 0, 3'd0, 0, 4'd3, 7'b1010110);
    vecs[2]  = mk(1, 0, 3'd0, 0, 4'd3, 7'b1110110);
    vecs[3]  = mk(1, 0, 3'd0, 0, 4'd3, 7'b1110110);
    vecs[4]  = mk(1, 0, 3'd0, 0, 4'd3, 7'b1110110);
    vecs[5]  = mk(1, 0, 3'd0, 0, 4'd3, 7'b1010111);
    vecs[6]  = mk(1, 0, 3'd0, 0, 4'd3, 7'b1010100);
    vecs[7]  = mk(1, 1, 3'd0, 1, 4'd2, 7'b1010100);
    vecs[8]  = mk(1, 1, 3'd7, 1, 4'd2, 7'b1000010);
    vecs[9]  = mk(1, 0, 3'd0, 0, 4'd2, 7'b1100010);
    vecs[10] = mk(1, 0, 3'd0, 0, 4'd2, 7'b1100010);
    vecs[11] = mk(1, 0, 3'd0, 0, 4'd2, 7'b1000011);
    vecs[12] = mk(1, 0, 3'd0, 0, 4'd2, 7'b1011110);
    vecs[13] = mk(1, 0, 3'd0, 0, 4'd2, 7'b1111110);
    vecs[14] = mk(1, 0, 3'd0, 0, 4'd2, 7'b1111110);
    vecs[15] = mk(1, 0, 3'd0, 0, 4'd2, 7'b1011111);
    vecs[16] = mk(1, 0, 3'd0, 0, 4'd2, 7'b1011100);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(dut_out()), 32'(7'b1000000));
    rst_n = 1'b1;
    #1;
    check("after_release", 32'(dut_out()), 32'(7'b1000000));

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].dest, vecs[i].data, vecs[i].hold);
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
      checkOutput($sformatf("vec%0d_model", i));
    end

    // Asynchronous reset in the middle of a drive phase, with entries still queued.
    applyStimulus(1'b1, 1'b1, 3'd6, 1'b1, 4'd8);
    applyStimulus(1'b1, 1'b1, 3'd2, 1'b1, 4'd8);
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b0, 4'd8);
    checkOutput("rst_pre");
    check("rst_pre_a", 32'(a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(dut_out()), 32'(7'b1000000));
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 4'd1);
      checkOutput("rst_fifo_empty");
    end

    // Fill the FIFO with en low, hold a fifth request, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 3'(i), 1'b1, 4'd1);
      checkOutput($sformatf("fill%0d", i));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 3'd5, 1'b1, 4'd1);
      checkOutput("full_hold");
    end
    done_order.delete();
    rdy = 1'b0;
    for (int i = 0; i < 10 && !rdy; i++) begin
      rdy = in_ready;
      applyStimulus(1'b1, 1'b1, 3'd5, 1'b1, 4'd1);
      checkOutput("full_accept");
      if (done === 1'b1) done_order.push_back({s0, s1, s2});
    end
    check("fifth_accepted", 32'(rdy), 32'd1);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 4'd1);
      checkOutput("drain");
      if (done === 1'b1) done_order.push_back({s0, s1, s2});
    end
    check("drain_count", 32'(done_order.size()), 32'd5);
    for (int i = 0; i < done_order.size() && i < 5; i++) begin
      check($sformatf("drain_order%0d", i), 32'(done_order[i]), 32'(i + 1));
    end

    // Hold-length corners: 0 acts as 1, maximum hold, and a data=0 slot.
    runEntry("hold0", 3'd4, 1'b1, 4'd0, 1, 3);
    runEntry("hold15", 3'd2, 1'b1, 4'd15, 15, 17);
    runEntry("data0", 3'd6, 1'b0, 4'd4, 0, 6);

    // Drop en mid-drive: current entry completes, two queued entries wait.
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 4'd4);
    applyStimulus(1'b1, 1'b1, 3'd2, 1'b1, 4'd4);
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b0, 4'd4);
    checkOutput("en_drive");
    d_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 4'd4);
      checkOutput("en_off");
      if (done === 1'b1) d_cnt++;
    end
    check("en_off_done", 32'(d_cnt), 32'd1);
    check("en_off_idle", 32'(busy), 32'd0);
    d_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 4'd4);
      checkOutput("en_on");
      if (done === 1'b1) d_cnt++;
    end
    check("en_on_done", 32'(d_cnt), 32'd2);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom % 8) != 0, $urandom % 2 == 0, 3'($urandom % 8),
                    1'($urandom % 2), HOLD_W'($urandom_range(0, 6)));
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/demux_sel_scheduler.md
Name: demux_sel_scheduler

Overview:
- Upstream sequencer for the 1-to-8 demultiplexer. Drives its data input `a` and its select lines `s0`, `s1`, `s2`.
- Accepts routing requests (destination channel plus data bit) over a valid/ready handshake and buffers them in a small FIFO.
- Replays each request as a timed, glitch-free select/data sequence. Select lines only ever change while `a` is low, so no unselected output pulses.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- HOLD_W, 4, width of the `hold_len` input.
- GUARD_CYCLES, 1, cycles `a` is held low after each drive phase before select may change; minimum 1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  when low, no new entry is popped; the entry in progress completes.
- hold_len  in  HOLD_W  drive duration in cycles; sampled at pop; value 0 is treated as 1.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when high (FIFO not full).
- in_dest  in  3  destination channel; bit2 maps to s0, bit1 to s1, bit0 to s2.
- in_data  in  1  bit routed to the selected output.
- a  out  1  data to the demux.
- s0  out  1  select MSB.
- s1  out  1  select middle bit.
- s2  out  1  select LSB.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the last GUARD cycle of each entry.

Behaviour:
- Reset (async, while rst_n low):
  - a, s0, s1, s2, busy, done all 0; FSM in IDLE.
  - FIFO pointers and count cleared.
  - in_ready reads 1 (FIFO empty).
  - Reset mid-operation drops `a` immediately and discards the current entry and all queued entries.
- Push: the entry is written at an edge where in_valid && in_ready.
  - in_ready = !full, registered-state only; it does not depend on a same-cycle pop.
  - A push while full is ignored; the source must hold it.
- All outputs are registered. a, s0, s1, s2 come from flops; no combinational path from inputs.
- FSM states: IDLE, SETUP, DRIVE, GUARD.
  - IDLE: a=0. If en && !empty at an edge: pop; load s0/s1/s2 from in_dest, data reg from in_data, hold counter from max(hold_len,1); go to SETUP.
  - SETUP: exactly 1 cycle. New select is visible, a=0. Go to DRIVE.
  - DRIVE: a = latched data bit for exactly the latched hold count of cycles, counted by a down-counter; then go to GUARD.
    - Data bit 0 still occupies the slot: a stays 0 for the hold.
  - GUARD: a=0, select unchanged, for GUARD_CYCLES cycles. done=1 on the final GUARD cycle. Exit:
    - if en && !empty: pop and go directly to SETUP, loading the new select at that edge;
    - else go to IDLE, with select holding its last value.
- Latency:
  - Push at edge E0 into an empty FIFO with FSM in IDLE and en=1: pop and select load at E1, a high from E2, a low from E2+N (N = effective hold).
  - Back-to-back entries: the select change is separated from the previous a-high phase by at least GUARD_CYCLES + 1 cycles (guard cycles plus the SETUP cycle).
- Simultaneous push and pop in one cycle: count unchanged; both take effect. The FIFO must handle this when full, and when empty the pushed entry is not popped in the same cycle.
- Pointer wrap-around modulo DEPTH.
- en deasserted during SETUP/DRIVE/GUARD: the current entry completes normally, then the FSM goes to IDLE. Queued entries are retained.
- hold_len changes mid-entry have no effect until the next pop.

Decomposition:
- Shared package demux_sched_pkg:
  - state enum (IDLE, SETUP, DRIVE, GUARD);
  - channel-index typedef (3-bit);
  - FIFO entry struct {dest[2:0], data};
  - localparam CHANNELS = 8.
- Sub-module sched_fifo: parameterised synchronous FIFO, DEPTH entries of 4 bits, with full/empty flags and async active-low reset.
- The FSM and counters live in the top level.

Test Plan:
- Reset behaviour: drive rst_n=0 mid-DRIVE with a=1 -> a, s0–s2, busy and done go to 0 without waiting for a clock edge; after release, in_ready=1 and the FIFO is empty.
- Single entry: dest=5, data=1, hold_len=3, GUARD_CYCLES=1 -> selects are s0=1, s1=0, s2=1 from E1; a=1 for exactly 3 cycles starting E2; done pulses once, on cycle E5; busy returns to 0 after the guard.
- Back-to-back entries: push dest=0, then dest=7 (data=1, hold=2) -> a goes low before the select changes from 000 to 111; exactly 2 low cycles (guard + SETUP) between a-high phases; the select is never observed changing while a=1.
- Full FIFO: en=0, push 5 entries with DEPTH=4 -> in_ready drops after the 4th; the 5th is held by the source. Then set en=1 -> all 4 drain in order (dests 1, 2, 3, 4), and the 5th is accepted once space frees.
- Hold-length corner cases: hold_len=0 -> 1-cycle drive; hold_len=15 -> 15-cycle drive. A data=0 entry with hold 4 -> a stays 0 for the whole slot, and done still pulses.
- en toggle: deassert en during DRIVE -> the current entry finishes and the FSM returns to IDLE; 2 queued entries are retained and execute after en is reasserted.
